// File: rtl/sd_status_pkg.sv
// Shared definitions for the SD socket status monitor: register offsets and debounce FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package sd_status_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_EDGECAP = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    CHECK = 2'd2
  } deb_state_t;

endpackage

// File: rtl/sd_status_monitor_if.sv
// Avalon-MM slave bus bundle for the SD socket status monitor.
// Latency: reads return one clk after the address is presented.
// Backpressure: none; the slave never inserts wait states.
interface sd_status_monitor_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/sd_debounce_ch.sv
// One status pin: 2-flop synchroniser, settle counter and debounce FSM.
// Latency: a clean level change reaches stable about 2 + DEBOUNCE_CYCLES clk after the pin moves.
// Backpressure: none; edge_pulse is a single-cycle strobe the parent must capture.
module sd_debounce_ch
  import sd_status_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic sync_lvl,
  output logic stable,
  output logic valid,
  output logic edge_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta;
  logic             sync_q;
  logic             sync_prev;
  deb_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             stable_nxt;
  logic             valid_nxt;

  assign sync_lvl = sync_q;

  // Bring the asynchronous pin into clk and keep one cycle of history for the initial settle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta      <= 1'b0;
      sync_q    <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      meta      <= pin;
      sync_q    <= meta;
      sync_prev <= sync_q;
    end
  end

  // FSM state, settle counter and accepted level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= INIT;
      cnt    <= '0;
      stable <= 1'b0;
      valid  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      stable <= stable_nxt;
      valid  <= valid_nxt;
    end
  end

  // Next-state logic: INIT waits for any level to hold, CHECK waits for a new level to hold.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    stable_nxt = stable;
    valid_nxt  = valid;
    edge_pulse = 1'b0;
    case (state)
      INIT: begin
        if (sync_q != sync_prev) begin
          cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
          // First accepted level after reset is not a change, so no edge.
          stable_nxt = sync_q;
          valid_nxt  = 1'b1;
          cnt_nxt    = '0;
          state_nxt  = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      IDLE: begin
        cnt_nxt = '0;
        if (sync_q != stable) begin
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (sync_q == stable) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          stable_nxt = sync_q;
          edge_pulse = 1'b1;
          cnt_nxt    = '0;
          state_nxt  = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = INIT;
      end
    endcase
  end

endmodule

// File: rtl/sd_status_monitor.sv
// SD socket status monitor: debounced wp_n/cd_n levels, edge capture and maskable IRQ on Avalon-MM.
// Latency: readdata one clk after address; irq one clk after an edge capture or mask change.
// Backpressure: none; no waitrequest, every access completes in one cycle.
module sd_status_monitor
  import sd_status_pkg::*;
#(
  parameter int NUM_IN          = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sd_status_monitor_if.slave   bus,
  input  logic [NUM_IN-1:0]    in_port,
  output logic                 irq
);

  logic [NUM_IN-1:0] sync_lvl;
  logic [NUM_IN-1:0] stable;
  logic [NUM_IN-1:0] valid;
  logic [NUM_IN-1:0] edge_pulse;
  logic [NUM_IN-1:0] irqmask;
  logic [NUM_IN-1:0] edgecap;
  logic [NUM_IN-1:0] ecap_clr;
  logic              wr_en;
  logic [31:0]       rd_nxt;
  logic              unused_wdata;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_ch
    sd_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .pin        (in_port[i]),
      .sync_lvl   (sync_lvl[i]),
      .stable     (stable[i]),
      .valid      (valid[i]),
      .edge_pulse (edge_pulse[i])
    );
  end

  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign unused_wdata = ^bus.writedata[31:NUM_IN];

  // W1C mask for the edge-capture register.
  always_comb begin
    ecap_clr = '0;
    if (wr_en && (bus.address == ADDR_EDGECAP)) begin
      ecap_clr = bus.writedata[NUM_IN-1:0];
    end
  end

  // Read mux; an unselected bus reads as zero.
  always_comb begin
    rd_nxt = '0;
    if (bus.chipselect) begin
      case (bus.address)
        ADDR_DATA:    rd_nxt[NUM_IN-1:0] = stable;
        ADDR_IRQMASK: rd_nxt[NUM_IN-1:0] = irqmask;
        ADDR_EDGECAP: rd_nxt[NUM_IN-1:0] = edgecap;
        ADDR_STATUS: begin
          rd_nxt[NUM_IN-1:0]  = valid;
          rd_nxt[16 +: NUM_IN] = sync_lvl;
        end
        default: rd_nxt = '0;
      endcase
    end
  end

  // Register file, edge capture (a new edge beats a same-cycle clear), read data and irq.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask      <= '0;
      edgecap      <= '0;
      bus.readdata <= '0;
      irq          <= 1'b0;
    end else begin
      if (wr_en && (bus.address == ADDR_IRQMASK)) begin
        irqmask <= bus.writedata[NUM_IN-1:0];
      end
      edgecap      <= (edgecap & ~ecap_clr) | edge_pulse;
      bus.readdata <= rd_nxt;
      irq          <= |(edgecap & irqmask);
    end
  end

endmodule

// File: tb/tb_sd_status_monitor.sv
// Bench for sd_status_monitor with a short debounce window and a run-length reference model.
// Latency: model tracks the registered read path and irq cycle by cycle.
// Backpressure: n/a.
module tb_sd_status_monitor;
  import sd_status_pkg::*;

  localparam int NUM_IN = 2;
  localparam int D      = 4;
  localparam int CNT_W  = 16;

  logic              clk     = 1'b0;
  logic              reset_n = 1'b0;
  logic [NUM_IN-1:0] in_port = 2'b11;
  logic              irq;

  sd_status_monitor_if bus_if ();

  sd_status_monitor #(
    .NUM_IN          (NUM_IN),
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (CNT_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if),
    .in_port (in_port),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a level is accepted once it has been seen on the synchronised pin
  // for long enough; the first level only needs to hold D samples, a change needs D+1.
  logic [NUM_IN-1:0] m_s1 = '0, m_s2 = '0, m_prev = '0;
  logic [NUM_IN-1:0] m_stable = '0, m_valid = '0, m_mask = '0, m_ecap = '0;
  int                m_run [NUM_IN];
  logic              m_irq = 1'b0;
  logic [31:0]       m_rd  = '0;

  task automatic model_step();
    logic [NUM_IN-1:0] edge_v;
    logic [NUM_IN-1:0] clr;
    logic [31:0]       rd;
    if (!reset_n) begin
      m_s1 = '0; m_s2 = '0; m_prev = '0;
      m_stable = '0; m_valid = '0; m_mask = '0; m_ecap = '0;
      m_irq = 1'b0; m_rd = '0;
      for (int i = 0; i < NUM_IN; i++) m_run[i] = 0;
    end else begin
      rd = '0;
      if (bus_if.chipselect) begin
        case (bus_if.address)
          ADDR_DATA:    rd[NUM_IN-1:0] = m_stable;
          ADDR_IRQMASK: rd[NUM_IN-1:0] = m_mask;
          ADDR_EDGECAP: rd[NUM_IN-1:0] = m_ecap;
          default: begin
            rd[NUM_IN-1:0]  = m_valid;
            rd[16 +: NUM_IN] = m_s2;
          end
        endcase
      end
      m_rd  = rd;
      m_irq = |(m_ecap & m_mask);
      edge_v = '0;
      for (int i = 0; i < NUM_IN; i++) begin
        if (!m_valid[i]) begin
          m_run[i] = (m_s2[i] == m_prev[i]) ? m_run[i] + 1 : 0;
          if (m_run[i] == D) begin
            m_stable[i] = m_s2[i];
            m_valid[i]  = 1'b1;
            m_run[i]    = 0;
          end
        end else begin
          m_run[i] = (m_s2[i] != m_stable[i]) ? m_run[i] + 1 : 0;
          if (m_run[i] == D + 1) begin
            m_stable[i] = m_s2[i];
            edge_v[i]   = 1'b1;
            m_run[i]    = 0;
          end
        end
      end
      clr = '0;
      if (bus_if.chipselect && !bus_if.write_n) begin
        if (bus_if.address == ADDR_IRQMASK) m_mask = bus_if.writedata[NUM_IN-1:0];
        if (bus_if.address == ADDR_EDGECAP) clr = bus_if.writedata[NUM_IN-1:0];
      end
      m_ecap = (m_ecap & ~clr) | edge_v;
      m_prev = m_s2;
      m_s2   = m_s1;
      m_s1   = in_port;
    end
  endtask

  always @(posedge clk or negedge reset_n) model_step();

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.chipselect = 1'b1; bus_if.write_n = 1'b0;
    bus_if.address = a; bus_if.writedata = d;
    @(negedge clk);
    bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_if.chipselect = 1'b1; bus_if.write_n = 1'b1; bus_if.address = a;
    @(negedge clk);
    d = bus_if.readdata;
    bus_if.chipselect = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int seen;
    reset_n = 1'b0; in_port = 2'b11;
    bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1;
    bus_if.address = '0; bus_if.writedata = '0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (bus_if.readdata !== 32'h0) begin
      n_err++; $display("FAIL reset_readdata got=%h want=%h", bus_if.readdata, 32'h0);
    end
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++; $display("FAIL reset_irq got=%b want=0", irq);
    end
    reset_n = 1'b1;
    bus_if.chipselect = 1'b1; bus_if.address = ADDR_STATUS;
    seen = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      n_vec++;
      if (bus_if.readdata !== m_rd) begin
        n_err++; $display("FAIL settle_track cyc=%0d got=%h want=%h", k, bus_if.readdata, m_rd);
      end
      if (seen == 0 && bus_if.readdata[1:0] == 2'b11) seen = k;
    end
    bus_if.chipselect = 1'b0;
    n_vec++;
    if (seen == 0 || seen > 9) begin
      n_err++; $display("FAIL settle_time got=%0d want=1..9", seen);
    end
    bus_read(ADDR_DATA, d);
    n_vec++;
    if (d !== 32'h3) begin
      n_err++; $display("FAIL reset_data got=%h want=%h", d, 32'h3);
    end
    bus_read(ADDR_EDGECAP, d);
    n_vec++;
    if (d !== 32'h0) begin
      n_err++; $display("FAIL reset_edgecap got=%h want=%h", d, 32'h0);
    end
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++; $display("FAIL reset_irq_settled got=%b want=0", irq);
    end
  endtask

  task automatic test_clean_change();
    logic [31:0] d;
    int seen;
    bus_write(ADDR_IRQMASK, 32'h2);
    bus_read(ADDR_IRQMASK, d);
    n_vec++;
    if (d !== 32'h2) begin
      n_err++; $display("FAIL irqmask_rb got=%h want=%h", d, 32'h2);
    end
    in_port[1] = 1'b0;
    bus_if.chipselect = 1'b1; bus_if.address = ADDR_DATA;
    seen = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      n_vec++;
      if (bus_if.readdata !== m_rd || irq !== m_irq) begin
        n_err++;
        $display("FAIL change_track cyc=%0d got=%h/%b want=%h/%b", k, bus_if.readdata, irq, m_rd, m_irq);
      end
      if (seen == 0 && bus_if.readdata[1] == 1'b0) seen = k;
    end
    bus_if.chipselect = 1'b0;
    n_vec++;
    if (seen < 6 || seen > 9) begin
      n_err++; $display("FAIL change_latency got=%0d want=6..9", seen);
    end
    bus_read(ADDR_EDGECAP, d);
    n_vec++;
    if (d !== 32'h2) begin
      n_err++; $display("FAIL change_edgecap got=%h want=%h", d, 32'h2);
    end
    n_vec++;
    if (irq !== 1'b1) begin
      n_err++; $display("FAIL change_irq got=%b want=1", irq);
    end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    @(negedge clk);
    in_port[0] = 1'b0;
    bus_if.chipselect = 1'b1; bus_if.address = ADDR_DATA;
    repeat (2) @(negedge clk);
    in_port[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      n_vec++;
      if (bus_if.readdata !== 32'h1 || irq !== 1'b1) begin
        n_err++;
        $display("FAIL glitch_hold cyc=%0d got=%h/%b want=%h/1", k, bus_if.readdata, irq, 32'h1);
      end
    end
    bus_if.chipselect = 1'b0;
    bus_read(ADDR_EDGECAP, d);
    n_vec++;
    if (d !== 32'h2) begin
      n_err++; $display("FAIL glitch_edgecap got=%h want=%h", d, 32'h2);
    end
  endtask

  task automatic test_w1c();
    logic [31:0] d;
    @(negedge clk);
    bus_if.chipselect = 1'b1; bus_if.write_n = 1'b0;
    bus_if.address = ADDR_EDGECAP; bus_if.writedata = 32'h2;
    @(negedge clk);
    bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1;
    n_vec++;
    if (irq !== 1'b1) begin
      n_err++; $display("FAIL w1c_irq_hold got=%b want=1", irq);
    end
    @(negedge clk);
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++; $display("FAIL w1c_irq_drop got=%b want=0", irq);
    end
    bus_read(ADDR_EDGECAP, d);
    n_vec++;
    if (d !== 32'h0) begin
      n_err++; $display("FAIL w1c_clear got=%h want=%h", d, 32'h0);
    end
    // Raise bit1 and land a clear of bit1 on the same edge that accepts the new level.
    @(negedge clk);
    in_port[1] = 1'b1;
    repeat (6) @(negedge clk);
    bus_if.chipselect = 1'b1; bus_if.write_n = 1'b0;
    bus_if.address = ADDR_EDGECAP; bus_if.writedata = 32'h2;
    @(negedge clk);
    bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1;
    bus_read(ADDR_EDGECAP, d);
    n_vec++;
    if (d !== 32'h2) begin
      n_err++; $display("FAIL collision_set_wins got=%h want=%h", d, 32'h2);
    end
    bus_read(ADDR_DATA, d);
    n_vec++;
    if (d !== 32'h3) begin
      n_err++; $display("FAIL collision_data got=%h want=%h", d, 32'h3);
    end
    n_vec++;
    if (irq !== 1'b1) begin
      n_err++; $display("FAIL collision_irq got=%b want=1", irq);
    end
  endtask

  task automatic test_mask_bus();
    logic [31:0] d;
    bus_write(ADDR_IRQMASK, 32'h0);
    bus_write(ADDR_EDGECAP, 32'h3);
    in_port[0] = 1'b0;
    repeat (12) @(negedge clk);
    bus_read(ADDR_EDGECAP, d);
    n_vec++;
    if (d !== 32'h1) begin
      n_err++; $display("FAIL mask_edgecap got=%h want=%h", d, 32'h1);
    end
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++; $display("FAIL masked_irq got=%b want=0", irq);
    end
    @(negedge clk);
    bus_if.chipselect = 1'b1; bus_if.write_n = 1'b0;
    bus_if.address = ADDR_IRQMASK; bus_if.writedata = 32'h1;
    @(negedge clk);
    bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1;
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++; $display("FAIL unmask_irq_early got=%b want=0", irq);
    end
    @(negedge clk);
    n_vec++;
    if (irq !== 1'b1) begin
      n_err++; $display("FAIL unmask_irq got=%b want=1", irq);
    end
    for (int a = 0; a < 4; a++) begin
      bus_if.chipselect = 1'b0; bus_if.address = 2'(a);
      @(negedge clk);
      n_vec++;
      if (bus_if.readdata !== 32'h0) begin
        n_err++; $display("FAIL nocs_read addr=%0d got=%h want=%h", a, bus_if.readdata, 32'h0);
      end
    end
    bus_write(ADDR_DATA, 32'hFFFF_FFFF);
    bus_read(ADDR_DATA, d);
    n_vec++;
    if (d !== 32'h2) begin
      n_err++; $display("FAIL data_ro got=%h want=%h", d, 32'h2);
    end
    bus_write(ADDR_STATUS, 32'h0);
    bus_read(ADDR_STATUS, d);
    n_vec++;
    if (d !== 32'h0002_0003) begin
      n_err++; $display("FAIL status_ro got=%h want=%h", d, 32'h0002_0003);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int seen;
    @(negedge clk);
    in_port[1] = 1'b0;
    bus_if.chipselect = 1'b1; bus_if.address = ADDR_DATA;
    repeat (4) @(negedge clk);
    n_vec++;
    if (bus_if.readdata !== 32'h2 || irq !== 1'b1) begin
      n_err++; $display("FAIL premid_state got=%h/%b want=%h/1", bus_if.readdata, irq, 32'h2);
    end
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if (bus_if.readdata !== 32'h0 || irq !== 1'b0) begin
      n_err++; $display("FAIL midreset_outputs got=%h/%b want=%h/0", bus_if.readdata, irq, 32'h0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    bus_if.address = ADDR_STATUS;
    seen = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      n_vec++;
      if (bus_if.readdata !== m_rd) begin
        n_err++; $display("FAIL resettle_track cyc=%0d got=%h want=%h", k, bus_if.readdata, m_rd);
      end
      if (seen == 0 && bus_if.readdata[1:0] == 2'b11) seen = k;
    end
    bus_if.chipselect = 1'b0;
    n_vec++;
    if (seen < D + 1) begin
      n_err++; $display("FAIL resettle_time got=%0d want>=%0d", seen, D + 1);
    end
    bus_read(ADDR_EDGECAP, d);
    n_vec++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      n_err++; $display("FAIL resettle_no_edge got=%h/%b want=%h/0", d, irq, 32'h0);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      n_vec++;
      if (bus_if.readdata !== m_rd || irq !== m_irq) begin
        n_err++;
        $display("FAIL random cyc=%0d got=%h/%b want=%h/%b", k, bus_if.readdata, irq, m_rd, m_irq);
      end
      if ($urandom_range(0, 5) == 0) in_port[$urandom_range(0, 1)] ^= 1'b1;
      bus_if.chipselect = ($urandom_range(0, 2) != 0);
      bus_if.write_n    = ($urandom_range(0, 3) != 0);
      bus_if.address    = 2'($urandom_range(0, 3));
      bus_if.writedata  = $urandom;
    end
    @(negedge clk);
    bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1;
  endtask

  initial begin
    bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1;
    bus_if.address = '0; bus_if.writedata = '0;
    test_reset();
    test_clean_change();
    test_glitch();
    test_w1c();
    test_mask_bus();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sd_status_monitor.md
Name: sd_status_monitor

Overview:
- Avalon-MM slave controller for the SD card socket status pins: write-protect (wp_n) and card-detect (cd_n).
- Replaces a bare level-sampling input port with:
  - 2-flop synchronisation
  - per-pin debounce state machine
  - edge capture
  - maskable interrupt
- Sits between the raw board pins and the Qsys interconnect; software reads settled levels and gets an IRQ on insert/remove or lock-switch change.

Parameters:
- NUM_IN, 2, number of monitored pins (bit0 = wp_n, bit1 = cd_n); range 1..8.
- DEBOUNCE_CYCLES, 50000, clk cycles an input must hold a new level before it is accepted (1 ms at 50 MHz); must be >= 2.
- CNT_W, 16, debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  2  Avalon word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  NUM_IN  raw asynchronous pin levels.
- irq  out  1  level interrupt, active high.

Behaviour:
- Clock and reset:
  - Single clock domain `clk`.
  - reset_n is asynchronous assert, active-low; all flops are cleared on assertion.
- Reset values:
  - readdata = 0, irq = 0.
  - Sync flops, stable levels, edgecapture, irqmask, valid and counters are all 0.
  - Every channel FSM starts in INIT.
- Synchroniser: in_port passes through 2 flops; sync[i] is the second stage. Debounce operates only on sync.
- Per-channel FSM:
  - INIT: counter increments while sync is unchanged from the previous cycle; any change reloads the counter to 0. When the counter reaches DEBOUNCE_CYCLES-1: stable <= sync, valid[i] <= 1, go to IDLE. No edge is captured on this transition.
  - IDLE: counter held at 0. If sync != stable, go to CHECK with counter = 0.
  - CHECK: if sync == stable, return to IDLE (glitch rejected). Otherwise, if the counter reaches DEBOUNCE_CYCLES-1: stable <= sync, edgecapture[i] <= 1, go to IDLE. Otherwise increment the counter.
  - Latency: a clean pin change becomes visible in stable 2 + DEBOUNCE_CYCLES cycles after the pin change (± 1 for sample alignment).
- Register map (word addresses; unused bits read 0, writes to them ignored):
  - 0 DATA (RO): bits[NUM_IN-1:0] = stable.
  - 1 IRQMASK (RW): bits[NUM_IN-1:0].
  - 2 EDGECAP (R/W1C): writing 1 to a bit clears it.
  - 3 STATUS (RO): bits[NUM_IN-1:0] = valid; bits[15+NUM_IN:16] = raw sync levels.
- Bus timing:
  - Read: readdata updates every clk with the mux of the addressed register when chipselect = 1, otherwise with 0. Read latency is 1 cycle, no waitrequest.
  - Write: takes effect when chipselect = 1 and write_n = 0, on that clk edge. Writes to 0 and 3 have no effect.
- Simultaneous events: edge set and W1C clear of the same bit in the same cycle leave the bit set (set wins).
- irq: registered, irq <= |(edgecapture & irqmask). It asserts 1 cycle after the edge or mask change and deasserts 1 cycle after clear.
- Reset mid-debounce: abandons progress; the channel re-enters INIT and must re-settle before valid = 1.

Decomposition:
- Package sd_status_pkg:
  - Register offset constants ADDR_DATA = 0, ADDR_IRQMASK = 1, ADDR_EDGECAP = 2, ADDR_STATUS = 3.
  - FSM state typedef {INIT, IDLE, CHECK}.
- Sub-module sd_debounce_ch:
  - Contents: one channel's synchroniser, counter and FSM.
  - Outputs: stable, valid, edge_pulse.
  - Instantiated NUM_IN times by generate.
- The top level holds the register file, W1C logic, read mux and irq flop.

Test Plan (DEBOUNCE_CYCLES = 4, NUM_IN = 2):
- Reset behaviour: release reset with in_port = 2'b11 held → STATUS valid = 2'b11 and DATA = 2'b11 within 8 cycles; EDGECAP = 0; irq = 0.
- Clean change with IRQ: after settle, IRQMASK = 2'b10; drop in_port[1] to 0 and hold → DATA bit1 = 0 about 6 cycles later; EDGECAP = 2'b10; irq = 1 the following cycle.
- Glitch rejection: pulse in_port[0] low for 2 cycles → DATA, EDGECAP and irq unchanged.
- W1C clear and collision: write EDGECAP = 2'b10 → bit clears and irq drops 1 cycle later. Repeat with the write landing on the same cycle as a new edge on bit1 → bit stays 1.
- Masking and bus rules: with EDGECAP = 2'b01 and IRQMASK = 0, irq = 0; write IRQMASK = 1 → irq = 1 next cycle. Read of any address with chipselect = 0 returns 0. Write to DATA has no effect.
- Reset mid-debounce: assert reset_n during CHECK → all outputs 0 immediately; after release, valid re-asserts only after a full settle and no spurious edge is captured.
